// File: rtl/trace_pkg.sv
// Shared definitions for the trace window controller: state encoding,
// default widths and the overflow counter ceiling.
package trace_pkg;

  localparam int PW_DEF    = 8;
  localparam int TW_DEF    = 32;
  localparam int CW_DEF    = 24;
  localparam int DEPTH_DEF = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DELAY = 3'd1;
  localparam logic [2:0] ST_ON    = 3'd2;
  localparam logic [2:0] ST_OFF   = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  localparam logic [15:0] OVF_SAT = 16'hFFFF;

endpackage

// File: rtl/trace_window_ctrl_if.sv
// Sample drain port: valid/ready handshake carrying a probe value and its
// timestamp. The controller drives it through the master modport.
interface trace_window_ctrl_if import trace_pkg::*; #(
  parameter int PW = PW_DEF,
  parameter int TW = TW_DEF
) ();

  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic [TW-1:0] out_time;

  modport master (
    output out_valid,
    output out_data,
    output out_time,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_time,
    output out_ready
  );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO. A write into a full FIFO is
// accepted only when a read retires the head in the same cycle.
module trace_fifo import trace_pkg::*; #(
  parameter int W     = PW_DEF + TW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/trace_window_ctrl.sv
// Recording scheduler: after an initial delay, opens a programmed number of
// ON windows separated by OFF gaps and logs change-only probe samples with
// a cycle timestamp into a small FWFT buffer for a downstream consumer.
module trace_window_ctrl import trace_pkg::*; #(
  parameter int PW    = PW_DEF,
  parameter int TW    = TW_DEF,
  parameter int CW    = CW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CW-1:0]          cfg_delay,
  input  logic [CW-1:0]          cfg_on,
  input  logic [CW-1:0]          cfg_off,
  input  logic [7:0]             cfg_windows,
  input  logic [PW-1:0]          probe,
  output logic                   rec_on,
  output logic                   busy,
  output logic                   done,
  trace_window_ctrl_if.master    obus,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            overflow_cnt
);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] on_len;
  logic [CW-1:0] off_len;
  logic [7:0]    win_left;
  logic [TW-1:0] ts;
  logic [PW-1:0] last_probe;

  logic [CW-1:0] on_len_cfg;
  logic          start_acc;
  logic          first_cyc;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [PW+TW-1:0] head;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == OVF_SAT) ? v : v + 16'd1;
  endfunction

  // A zero-length ON window is treated as one cycle long.
  assign on_len_cfg = (cfg_on == '0) ? CW'(1) : cfg_on;
  assign start_acc  = (state == ST_IDLE) && start && !abort;
  // cnt counts down from on_len-1, so the first cycle has the full value.
  assign first_cyc  = (cnt == on_len - CW'(1));
  assign push       = (state == ST_ON) && (first_cyc || (probe != last_probe));
  assign pop        = obus.out_valid && obus.out_ready;

  assign rec_on = (state == ST_ON);
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_FIN);

  // Schedule sequencer: cnt holds the cycles remaining in the current phase minus one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      on_len   <= '0;
      off_len  <= '0;
      win_left <= '0;
    end else if (abort && (state != ST_IDLE)) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_acc) begin
            on_len   <= on_len_cfg;
            off_len  <= cfg_off;
            win_left <= cfg_windows;
            if (cfg_windows == 8'd0) begin
              state <= ST_FIN;
            end else if (cfg_delay == '0) begin
              state <= ST_ON;
              cnt   <= on_len_cfg - CW'(1);
            end else begin
              state <= ST_DELAY;
              cnt   <= cfg_delay - CW'(1);
            end
          end
        end
        ST_DELAY, ST_OFF: begin
          if (cnt == '0) begin
            state <= ST_ON;
            cnt   <= on_len - CW'(1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_ON: begin
          if (cnt == '0) begin
            win_left <= win_left - 8'd1;
            if (win_left == 8'd1) begin
              state <= ST_FIN;
            end else if (off_len == '0) begin
              cnt <= on_len - CW'(1);
            end else begin
              state <= ST_OFF;
              cnt   <= off_len - CW'(1);
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Cycle timestamp: restarts at schedule start, advances while busy, holds in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n)         ts <= '0;
    else if (start_acc) ts <= '0;
    else if (busy)      ts <= ts + TW'(1);
  end

  // Reference value for change detection, refreshed in every ON cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)              last_probe <= '0;
    else if (state == ST_ON) last_probe <= probe;
  end

  // Dropped-sample counter: a push is lost only when full and nothing retires.
  always_ff @(posedge clk) begin
    if (!rst_n)                          overflow_cnt <= '0;
    else if (start_acc)                  overflow_cnt <= '0;
    else if (push && fifo_full && !pop)  overflow_cnt <= sat_inc(overflow_cnt);
  end

  trace_fifo #(
    .W     (PW + TW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data ({probe, ts}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign obus.out_valid = !fifo_empty;
  assign obus.out_data  = head[PW+TW-1:TW];
  assign obus.out_time  = head[TW-1:0];

endmodule

// File: tb/tb_trace_window_ctrl.sv
// Directed bench for trace_window_ctrl with a scoreboard of expected
// buffer entries checked as the consumer pops them.
module tb_trace_window_ctrl;

  localparam int PW    = 8;
  localparam int TW    = 32;
  localparam int CW    = 24;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [CW-1:0] cfg_delay;
  logic [CW-1:0] cfg_on;
  logic [CW-1:0] cfg_off;
  logic [7:0]    cfg_windows;
  logic [PW-1:0] probe;
  logic          rec_on;
  logic          busy;
  logic          done;
  logic [3:0]    fifo_level;
  logic [15:0]   overflow_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [PW+TW-1:0] sb [$];

  trace_window_ctrl_if #(.PW(PW), .TW(TW)) obus ();

  trace_window_ctrl #(
    .PW(PW), .TW(TW), .CW(CW), .DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .cfg_delay    (cfg_delay),
    .cfg_on       (cfg_on),
    .cfg_off      (cfg_off),
    .cfg_windows  (cfg_windows),
    .probe        (probe),
    .rec_on       (rec_on),
    .busy         (busy),
    .done         (done),
    .obus         (obus),
    .fifo_level   (fifo_level),
    .overflow_cnt (overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sched(input int d, input int o, input int f, input int w);
    cfg_delay   = CW'(d);
    cfg_on      = CW'(o);
    cfg_off     = CW'(f);
    cfg_windows = 8'(w);
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && obus.out_valid === 1'b1; i++) step();
    chk({tag, "_drained"}, 64'(obus.out_valid), 64'd0);
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  // Consumer-side scoreboard: every accepted pop must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && obus.out_valid === 1'b1 && obus.out_ready === 1'b1) begin
      chk("sb_has_expect", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) chk("sb_entry", 64'({obus.out_data, obus.out_time}), 64'(sb.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_delay = '0; cfg_on = '0; cfg_off = '0; cfg_windows = '0;
    probe = '0; obus.out_ready = 1'b0;
    step(); step();
    chk("rst_rec_on", 64'(rec_on), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(obus.out_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf", 64'(overflow_cnt), 64'd0);
    rst_n = 1'b1;
    step();

    // Normal schedule: delay 3, on 4, off 2, two windows.
    probe = 8'h5A;
    obus.out_ready = 1'b1;
    sb.push_back({8'h5A, 32'd3});
    sb.push_back({8'h5A, 32'd9});
    start_sched(3, 4, 2, 2);
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("norm_rec_on_c%0d", c), 64'(rec_on),
          64'(((c >= 3) && (c <= 6)) || ((c >= 9) && (c <= 12))));
      chk($sformatf("norm_done_c%0d", c), 64'(done), 64'(c == 13));
      chk($sformatf("norm_busy_c%0d", c), 64'(busy), 64'(c <= 13));
      step();
    end
    chk("norm_ovf", 64'(overflow_cnt), 64'd0);
    wait_drain("norm");

    // Overflow: probe changes every cycle with the consumer stalled.
    obus.out_ready = 1'b0;
    probe = 8'h10;
    start_sched(0, 12, 0, 1);
    for (int t = 0; t < 14; t++) begin
      probe = 8'h10 + 8'(t);
      if (t < 8) sb.push_back({8'h10 + 8'(t), 32'(t)});
      step();
    end
    chk("ovf_level", 64'(fifo_level), 64'd8);
    chk("ovf_cnt", 64'(overflow_cnt), 64'd4);
    chk("ovf_busy", 64'(busy), 64'd0);
    obus.out_ready = 1'b1;
    wait_drain("ovf");
    obus.out_ready = 1'b0;

    // Zero windows: straight to FIN.
    start_sched(5, 5, 5, 0);
    chk("zw_done_c0", 64'(done), 64'd1);
    chk("zw_busy_c0", 64'(busy), 64'd1);
    chk("zw_rec_on_c0", 64'(rec_on), 64'd0);
    step();
    chk("zw_done_c1", 64'(done), 64'd0);
    chk("zw_busy_c1", 64'(busy), 64'd0);
    chk("zw_rec_on_c1", 64'(rec_on), 64'd0);
    chk("zw_level", 64'(fifo_level), 64'd0);

    // Abort mid-window with two entries buffered; start alongside abort is ignored.
    probe = 8'h33;
    sb.push_back({8'h33, 32'd0});
    start_sched(0, 1, 0, 1);
    step(); step();
    probe = 8'hA1;
    sb.push_back({8'hA1, 32'd0});
    start_sched(0, 4, 0, 1);
    chk("ab_rec_on_c0", 64'(rec_on), 64'd1);
    step();
    chk("ab_level_c1", 64'(fifo_level), 64'd2);
    chk("ab_rec_on_c1", 64'(rec_on), 64'd1);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("ab_rec_on_c2", 64'(rec_on), 64'd0);
    chk("ab_busy_c2", 64'(busy), 64'd0);
    chk("ab_done_c2", 64'(done), 64'd0);
    chk("ab_level_c2", 64'(fifo_level), 64'd2);
    step();
    chk("ab_busy_c3", 64'(busy), 64'd0);
    chk("ab_done_c3", 64'(done), 64'd0);
    obus.out_ready = 1'b1;
    wait_drain("ab");
    obus.out_ready = 1'b0;

    // Reset during OFF with three entries buffered.
    probe = 8'h01;
    start_sched(0, 3, 5, 2);
    step();
    probe = 8'h02;
    step();
    probe = 8'h03;
    step();
    chk("rs_level_off", 64'(fifo_level), 64'd3);
    chk("rs_busy_off", 64'(busy), 64'd1);
    chk("rs_rec_on_off", 64'(rec_on), 64'd0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rs_rec_on", 64'(rec_on), 64'd0);
    chk("rs_busy", 64'(busy), 64'd0);
    chk("rs_done", 64'(done), 64'd0);
    chk("rs_valid", 64'(obus.out_valid), 64'd0);
    chk("rs_level", 64'(fifo_level), 64'd0);
    chk("rs_ovf", 64'(overflow_cnt), 64'd0);
    sb.delete();
    step();
    chk("rs_busy_after", 64'(busy), 64'd0);

    // Full buffer with simultaneous push and pop.
    probe = 8'h40;
    start_sched(0, 12, 0, 1);
    for (int t = 0; t < 14; t++) begin
      probe = (t <= 8) ? 8'h40 + 8'(t) : 8'h48;
      if (t <= 8) sb.push_back({8'h40 + 8'(t), 32'(t)});
      obus.out_ready = (t == 8);
      if (t == 8) chk("pp_level_full", 64'(fifo_level), 64'd8);
      if (t == 9) begin
        chk("pp_level_after", 64'(fifo_level), 64'd8);
        chk("pp_ovf_after", 64'(overflow_cnt), 64'd0);
      end
      step();
    end
    obus.out_ready = 1'b0;
    chk("pp_ovf_end", 64'(overflow_cnt), 64'd0);
    obus.out_ready = 1'b1;
    wait_drain("pp");
    obus.out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
